ddr3_wr_burst_ctrl: RTL

DDR3_WR_BURST_CTRL -- requirements
Module: ddr3_wr_burst_ctrl

---
 rtl/ddr3_wr_burst_ctrl_pkg.sv | 19 +
 rtl/ddr3_wr_skid_buf.sv | 58 +++++
 rtl/ddr3_wr_burst_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ddr3_wr_burst_ctrl_pkg.sv
// Shared types and constants for the DDR3 write-burst controller.
package ddr3_wr_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

  // Bytes covered by one write burst.
  function automatic int unsigned burst_bytes(input int unsigned data_width,
                                              input int unsigned burst_len);
    return burst_len * (data_width / 8);
  endfunction

endpackage

// File: rtl/ddr3_wr_skid_buf.sv
// Two-entry skid buffer fed by a source with one cycle of read latency.
// A word arriving while the buffer is empty and the sink is ready passes
// straight through, so a continuous stream moves one word per cycle while
// stored plus in-flight words never exceed two.
module ddr3_wr_skid_buf
  import ddr3_wr_burst_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  can_req
);

  logic                  inflight;
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  stored_valid;
  logic                  pop;
  logic                  pop_mem;
  logic                  push;

  assign stored_valid = (count != 2'd0);
  assign out_valid    = stored_valid | inflight;
  assign out_data     = stored_valid ? mem[rd_ptr] : in_data;
  assign pop          = out_valid & out_ready;
  assign pop_mem      = pop & stored_valid;
  assign push         = inflight & ~(pop & ~stored_valid);
  assign can_req      = (count == 2'd0) || ((count == 2'd1) && !inflight);

  // Track the outstanding read and the occupancy/pointers of the two slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= req;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop_mem) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop_mem);
    end
  end

  // Storage slots need no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/ddr3_wr_burst_ctrl.sv
// Drains a FIFO into fixed-length AXI-style write bursts over a ring
// address region, one burst at a time.
module ddr3_wr_burst_ctrl
  import ddr3_wr_burst_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned ADDR_WIDTH   = 28,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned LEVEL_WIDTH  = 7,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned REGION_BYTES = 2**20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  output logic                   fifo_rd_en,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_level,
  output logic [ADDR_WIDTH-1:0]  awaddr,
  output logic [7:0]             awlen,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic                   wvalid,
  input  logic                   wready,
  output logic                   wlast,
  input  logic                   bvalid,
  input  logic [1:0]             bresp,
  output logic                   bready,
  output logic                   busy,
  output logic                   burst_done,
  output logic                   wr_err
);

  localparam int unsigned           CNT_W       = $clog2(BURST_LEN) + 1;
  localparam int unsigned           BURST_BYTES = burst_bytes(DATA_WIDTH, BURST_LEN);
  localparam logic [CNT_W-1:0]      BEATS       = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   STEP        = (ADDR_WIDTH + 1)'(BURST_BYTES);
  localparam logic [ADDR_WIDTH:0]   LIMIT       = (ADDR_WIDTH + 1)'(BASE_ADDR + REGION_BYTES);

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        req_cnt;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    start;
  logic                    beat;
  logic                    buf_valid;
  logic [DATA_WIDTH-1:0]   buf_data;
  logic                    buf_ready;
  logic                    can_req;
  logic [ADDR_WIDTH:0]     next_addr;

  assign start      = (state == IDLE) && enable && (32'(fifo_rd_level) >= BURST_LEN);
  assign busy       = (state != IDLE);
  assign burst_done = (state == RESP) && bvalid;
  assign awlen      = 8'(BURST_LEN - 1);
  assign buf_ready  = (state == DATA) && wready;
  assign wvalid     = (state == DATA) && buf_valid;
  assign wdata      = wvalid ? buf_data : '0;
  assign wlast      = wvalid && (beat_cnt == LAST_BEAT);
  assign beat       = wvalid && wready;
  assign next_addr  = {1'b0, awaddr} + STEP;
  assign fifo_rd_en = ((state == ADDR) || (state == DATA)) && (req_cnt < BEATS) &&
                      !fifo_rd_empty && can_req;

  ddr3_wr_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (fifo_rd_en),
    .in_data  (fifo_rd_data),
    .out_ready(buf_ready),
    .out_valid(buf_valid),
    .out_data (buf_data),
    .can_req  (can_req)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic plus the per-state handshake strobes.
  always_comb begin
    state_next = state;
    awvalid    = 1'b0;
    bready     = 1'b0;
    case (state)
      IDLE: if (start) state_next = ADDR;
      ADDR: begin
        awvalid = 1'b1;
        if (awready) state_next = DATA;
      end
      DATA: if (beat && (beat_cnt == LAST_BEAT)) state_next = RESP;
      RESP: begin
        bready = 1'b1;
        if (bvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-burst counts of FIFO words requested and beats delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt  <= '0;
      beat_cnt <= '0;
    end else if (start) begin
      req_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      if (fifo_rd_en) req_cnt  <= req_cnt + CNT_W'(1);
      if (beat)       beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  // Ring address: step one burst per accepted address, wrap at region end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr <= BASE;
    end else if (awvalid && awready) begin
      awaddr <= (next_addr >= LIMIT) ? BASE : next_addr[ADDR_WIDTH-1:0];
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 wr_err <= 1'b0;
    else if (burst_done && (bresp != BRESP_OKAY)) wr_err <= 1'b1;
  end

endmodule
